// File: rtl/addr_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width and
// the nibble-select helper used to feed the single adder slice.
package addr_pkg;

    localparam int NIBBLE = 4;
    // Widest operand the nibble helper can index into.
    localparam int MAXW   = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Returns nibble number idx of vec (idx 0 = least significant nibble).
    function automatic logic [NIBBLE-1:0] nib(input logic [MAXW-1:0] vec,
                                              input int unsigned    idx);
        return vec[NIBBLE*idx +: NIBBLE];
    endfunction

endpackage

// File: rtl/nibble_add4u.sv
// Combinational 4-bit unsigned adder slice: {carry, sum} = a + b + cin.
module nibble_add4u
    import addr_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE:0]   s
);

    assign s = {1'b0, a} + {1'b0, b} + {{NIBBLE{1'b0}}, cin};

endmodule

// File: rtl/addr_nibble_serial.sv
// Multi-cycle unsigned adder: one nibble per clock through a single 4-bit
// slice, registered carry between nibbles, valid/ready on both sides.
// WIDTH must be a multiple of 4, at least 8 and at most MAXW.
module addr_nibble_serial
    import addr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB  = WIDTH / NIBBLE;
    localparam int IDXW = $clog2(NIB);

    state_e             state, state_nx;
    logic [WIDTH-1:0]   a_q, b_q, sum_q;
    logic               carry_q, cout_q;
    logic [IDXW-1:0]    idx;
    logic               accept, last;
    logic [NIBBLE-1:0]  nib_a, nib_b;
    logic [NIBBLE:0]    slice;

    // Ready is masked by reset so nothing is accepted while rst_n is low.
    assign in_ready = (state == S_IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign last     = (idx == IDXW'(NIB - 1));

    // Operand nibble mux feeding the one shared slice.
    assign nib_a = nib(MAXW'(a_q), 32'(idx));
    assign nib_b = nib(MAXW'(b_q), 32'(idx));

    nibble_add4u u_slice (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q),
        .s   (slice)
    );

    assign sum  = sum_q;
    assign cout = cout_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (accept) state_nx = S_RUN;
            end
            S_RUN: begin
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                busy     = 1'b0;
            end
        endcase
    end

    // Operand capture, nibble counter, carry chain and result registers.
    // sum/cout are only written in RUN, so they hold steady through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx     <= '0;
                    end
                end
                S_RUN: begin
                    sum_q[NIBBLE*idx +: NIBBLE] <= slice[NIBBLE-1:0];
                    carry_q                     <= slice[NIBBLE];
                    // idx parks at NIB-1 on the final nibble instead of wrapping.
                    if (last) cout_q <= slice[NIBBLE];
                    else      idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_nibble_serial.sv
// Scoreboard bench: three adders (WIDTH 16, 8, 32). Accepted operands push the
// arithmetic result into a per-instance queue; a monitor pops on each output
// handshake and also checks that a stalled result stays put.
module tb_addr_nibble_serial;

    localparam int W [3] = '{16, 8, 32};

    logic        clk, rst_n;
    logic        in_valid_v  [3];
    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic        out_ready_v [3];
    logic        cin_v       [3];
    logic        cout_v      [3];
    logic        busy_v      [3];
    logic [31:0] a_v         [3];
    logic [31:0] b_v         [3];
    logic [31:0] sum_v       [3];
    logic [15:0] sum16;
    logic [7:0]  sum8;
    logic [31:0] sum32;

    int checks = 0;
    int errors = 0;
    int acc_n [3];

    logic [32:0] expq [3][$];
    logic        held     [3];
    logic [32:0] held_val [3];

    assign sum_v[0] = {16'b0, sum16};
    assign sum_v[1] = {24'b0, sum8};
    assign sum_v[2] = sum32;

    addr_nibble_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][15:0]), .b(b_v[0][15:0]), .cin(cin_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum16), .cout(cout_v[0]), .busy(busy_v[0]));

    addr_nibble_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum8), .cout(cout_v[1]), .busy(busy_v[1]));

    addr_nibble_serial #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum32), .cout(cout_v[2]), .busy(busy_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: plain wide addition, then split into {cout, sum}.
    function automatic logic [32:0] model(input int w, input logic [31:0] x,
                                          input logic [31:0] y, input logic c);
        logic [63:0] t;
        logic [32:0] r;
        t = {32'b0, x & wmask(w)} + {32'b0, y & wmask(w)} + {63'b0, c};
        r[31:0] = t[31:0] & wmask(w);
        r[32]   = t[w];
        return r;
    endfunction

    function automatic logic [31:0] rnd(input int w);
        logic [31:0] r;
        case ($urandom % 4)
            0:       r = 32'hFFFF_FFFF;
            1:       r = $urandom % 16;
            default: r = $urandom;
        endcase
        return r & wmask(w);
    endfunction

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, inputs change after rising edges.
    initial begin
        logic [32:0] got, e;
        for (int i = 0; i < 3; i++) begin
            held[i] = 1'b0;
            acc_n[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    expq[i].delete();
                    held[i] = 1'b0;
                end else begin
                    if (in_valid_v[i] && in_ready_v[i]) begin
                        expq[i].push_back(model(W[i], a_v[i], b_v[i], cin_v[i]));
                        acc_n[i]++;
                    end
                    got = {cout_v[i], sum_v[i]};
                    if (held[i]) begin
                        checks++;
                        if (!out_valid_v[i]) begin
                            errors++;
                            $display("FAIL hold_w%0d: out_valid dropped without out_ready", W[i]);
                        end else if (got !== held_val[i]) begin
                            errors++;
                            $display("FAIL stable_w%0d: got %h expected %h", W[i], got, held_val[i]);
                        end
                    end
                    held[i] = 1'b0;
                    if (out_valid_v[i]) begin
                        if (out_ready_v[i]) begin
                            checks++;
                            if (expq[i].size() == 0) begin
                                errors++;
                                $display("FAIL result_w%0d: unexpected result %h, nothing expected", W[i], got);
                            end else begin
                                e = expq[i].pop_front();
                                if (got !== e) begin
                                    errors++;
                                    $display("FAIL result_w%0d: got %h expected %h", W[i], got, e);
                                end
                            end
                        end else begin
                            held[i]     = 1'b1;
                            held_val[i] = got;
                        end
                    end
                end
            end
        end
    end

    // Present operands on instance 0 until accepted; returns just after the accept edge.
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic c);
        int n = 0;
        a_v[0] = x; b_v[0] = y; cin_v[0] = c; in_valid_v[0] = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready_v[0]) break;
            @(posedge clk); #1;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 33'(n), 33'(0));
                break;
            end
        end
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
    endtask

    // Counts rising edges from the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid_v[0]) break;
            @(posedge clk); #1;
            lat++;
            if (lat > 50) begin
                chk("out_timeout", 33'(lat), 33'(0));
                break;
            end
        end
    endtask

    task automatic take();
        @(posedge clk); #1;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[0] = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int start, cyc;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  33'(in_ready_v[0]),  33'(0));
        chk("rst_out_valid", 33'(out_valid_v[0]), 33'(0));
        chk("rst_sum",       33'(sum_v[0]),       33'(0));
        chk("rst_cout",      33'(cout_v[0]),      33'(0));
        chk("rst_busy",      33'(busy_v[0]),      33'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 33'(in_ready_v[0]), 33'(1));

        // Basic op and latency.
        @(posedge clk); #1;
        send(32'h1234, 32'h4321, 1'b0);
        wait_out(lat);
        chk("latency", 33'(lat), 33'(4));
        take();

        // Full carry ripple.
        send(32'hFFFF, 32'h0001, 1'b0);
        wait_out(lat);
        take();
        send(32'hFFFF, 32'hFFFF, 1'b1);
        wait_out(lat);

        // Backpressure: result held, inputs ignored.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid_v[0] = 1'($urandom);
            a_v[0] = $urandom & 32'hFFFF;
            b_v[0] = $urandom & 32'hFFFF;
            cin_v[0] = 1'($urandom);
            @(negedge clk);
            chk("bp_in_ready", 33'(in_ready_v[0]), 33'(0));
            chk("bp_busy",     33'(busy_v[0]),     33'(1));
        end
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        take();
        send(32'h00AB, 32'h0011, 1'b1);
        wait_out(lat);
        take();

        // Reset in the middle of RUN (idx == 2).
        send(32'hAAAA, 32'h5555, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 33'(out_valid_v[0]), 33'(0));
        chk("mid_rst_busy",      33'(busy_v[0]),      33'(0));
        chk("mid_rst_sum",       33'(sum_v[0]),       33'(0));
        chk("mid_rst_cout",      33'(cout_v[0]),      33'(0));
        chk("mid_rst_in_ready",  33'(in_ready_v[0]),  33'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 33'(out_valid_v[0]), 33'(0));
        end
        @(posedge clk); #1;
        send(32'h0F0F, 32'h00F1, 1'b0);
        wait_out(lat);
        take();

        // Random traffic with stalls on all three widths.
        start = acc_n[0];
        cyc = 0;
        while (acc_n[0] < start + 2000 && cyc < 40000) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                in_valid_v[i]  = ($urandom % 3) != 0;
                a_v[i]         = rnd(W[i]);
                b_v[i]         = rnd(W[i]);
                cin_v[i]       = 1'($urandom);
                out_ready_v[i] = ($urandom % 3) != 0;
            end
            cyc++;
        end
        chk("random_ops_done", 33'(acc_n[0] >= start + 2000), 33'(1));

        // Drain and confirm every accepted op produced exactly one result.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i] = 1'b0;
            out_ready_v[i] = 1'b1;
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("drain_empty", 33'(expq[i].size()), 33'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
